clk_div: RTL and testbench
==========================

CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 The block SHALL have no parameters; the division ratios SHALL be fixed at 8 and 16.
REQ-002 clk16MHz  input  1  source clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clk2MHz  output  1  clk16MHz divided by 8, 50% duty cycle.
REQ-005 clk1MHz  output  1  clk16MHz divided by 16, 50% duty cycle.
REQ-006 Port order SHALL be clk16MHz, reset, clk2MHz, clk1MHz, so that positional instantiation binds correctly.

Function
REQ-007 The block SHALL contain a 4-bit up-counter cnt that increments by 1 on every rising edge of clk16MHz while reset is low.
REQ-008 cnt SHALL wrap from 15 to 0 with no idle cycle.
REQ-009 clk2MHz SHALL be driven directly by the flop cnt[2], with no combinational decode, so the output is glitch-free.
REQ-010 clk1MHz SHALL be driven directly by the flop cnt[3].
REQ-011 Counting edges after reset release are numbered N = 1, 2, 3, ...; after edge N, cnt SHALL equal N mod 16.
REQ-012 clk2MHz SHALL rise after edge 4 and fall after edge 8, and then repeat with a period of 8 clk16MHz cycles (high 4, low 4).
REQ-013 clk1MHz SHALL rise after edge 8 and fall after edge 16, with a period of 16 cycles (high 8, low 8).
REQ-014 Both outputs SHALL fall on the same edge (cnt 15 to 0); every clk1MHz edge SHALL coincide with a clk2MHz edge.
REQ-015 Output latency from reset release to the first clk2MHz rising edge SHALL be exactly 4 clk16MHz rising edges.

Reset
REQ-016 Asserting reset SHALL immediately force cnt to 0, clk2MHz to 0 and clk1MHz to 0, independent of clk16MHz.
REQ-017 Reset asserted mid-period SHALL truncate the current output phase; no partial pulse SHALL be extended.
REQ-018 Counting after reset deassertion SHALL start from edge 1 as in REQ-011.
REQ-019 A rising clock edge coincident with reset deassertion SHALL NOT be counted.
REQ-020 While reset is held high, all outputs SHALL stay 0 for any number of clock edges.

Configuration
REQ-021 When the macro CLKDIV_STROBE_EN is defined, the block SHALL add output strb2MHz (1 bit) after clk1MHz.
REQ-022 strb2MHz SHALL be a registered signal that is high for exactly one clk16MHz cycle while cnt[2:0] equals 4, i.e. coincident with each clk2MHz rising edge.
REQ-023 When CLKDIV_STROBE_EN is defined, the block SHALL also add output strb1MHz (1 bit) after strb2MHz.
REQ-024 strb1MHz SHALL be a registered signal that is high for exactly one cycle while cnt equals 8.
REQ-025 Both strobes SHALL reset asynchronously to 0.
REQ-026 When CLKDIV_STROBE_EN is undefined, the strobe ports and their logic SHALL be absent, and the port list SHALL be exactly REQ-002 to REQ-005.

Verification
REQ-027 Power-up reset: reset=1 for 0 to 50 ns with clk16MHz period 50 ns -> clk2MHz=0 and clk1MHz=0 throughout.
REQ-028 Free run after reset release for 10000 ns -> clk2MHz period 400 ns (200 ns high, 200 ns low) and clk1MHz period 800 ns (400 ns high, 400 ns low).
REQ-029 Edge count check: after reset release -> clk2MHz rises after edge 4, clk1MHz rises after edge 8, and both fall after edge 16 and after every 16th edge thereafter.
REQ-030 Mid-operation reset: assert reset asynchronously while cnt=13 -> both outputs go to 0 within the same delta, without waiting for a clock edge.
REQ-031 Recovery: release that reset -> clk2MHz rises again exactly 4 edges later.
REQ-032 With CLKDIV_STROBE_EN defined, over 160 cycles -> strb2MHz fires 20 single-cycle pulses aligned to clk2MHz rising edges, and strb1MHz fires 10 single-cycle pulses aligned to clk1MHz rising edges.

Source files
------------

// File: rtl/clk_div.sv
// Fixed /8 and /16 clock divider built on a free-running 4-bit counter.
// Optional one-cycle strobes at each divided-clock rising edge: define CLKDIV_STROBE_EN.
module clk_div (
    input  logic clk16MHz,
    input  logic reset,
    output logic clk2MHz,
    output logic clk1MHz
`ifdef CLKDIV_STROBE_EN
    ,
    output logic strb2MHz,
    output logic strb1MHz
`endif
);

    localparam int unsigned CntW = 4;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Wraps 15 -> 0 naturally through the 4-bit add.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
    end

    always_ff @(posedge clk16MHz or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Outputs come straight from counter flops so they cannot glitch.
    assign clk2MHz = cnt_q[2];
    assign clk1MHz = cnt_q[3];

`ifdef CLKDIV_STROBE_EN
    logic strb2_q;
    logic strb1_q;

    // Decoded from the next count so each strobe is high while cnt holds its value.
    always_ff @(posedge clk16MHz or posedge reset) begin
        if (reset) begin
            strb2_q <= 1'b0;
            strb1_q <= 1'b0;
        end else begin
            strb2_q <= (cnt_d[2:0] == 3'd4);
            strb1_q <= (cnt_d == CntW'(8));
        end
    end

    assign strb2MHz = strb2_q;
    assign strb1MHz = strb1_q;
`endif

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: edge-count vector table, period measurement,
// async reset corner cases and randomized reset/run sequences against an edge-count model.
module tb_clk_div;

    logic clk16MHz = 1'b0;
    logic reset    = 1'b1;
    logic clk2MHz;
    logic clk1MHz;
`ifdef CLKDIV_STROBE_EN
    logic strb2MHz;
    logic strb1MHz;
`endif

    clk_div dut (
        .clk16MHz (clk16MHz),
        .reset    (reset),
        .clk2MHz  (clk2MHz),
        .clk1MHz  (clk1MHz)
`ifdef CLKDIV_STROBE_EN
        ,
        .strb2MHz (strb2MHz),
        .strb1MHz (strb1MHz)
`endif
    );

    always #25 clk16MHz = ~clk16MHz;

    int checks = 0;
    int errors = 0;
    int n      = 0;   // counting edges since the last reset release

    typedef struct {
        int   edge_n;
        logic exp2;
        logic exp1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t (edge %0d): got %0d expected %0d", nm, $time, n, act, exp);
        end
    endtask

    // Reference model: output levels follow directly from the edge number.
    function automatic logic model2(input int e);
        return ((e % 8) >= 4);
    endfunction

    function automatic logic model1(input int e);
        return ((e % 16) >= 8);
    endfunction

    task automatic step();
        @(posedge clk16MHz);
        #1;
        n++;
        chk("model_clk2", {31'd0, clk2MHz}, {31'd0, model2(n)});
        chk("model_clk1", {31'd0, clk1MHz}, {31'd0, model1(n)});
`ifdef CLKDIV_STROBE_EN
        chk("model_strb2", {31'd0, strb2MHz}, {31'd0, ((n % 8) == 4)});
        chk("model_strb1", {31'd0, strb1MHz}, {31'd0, ((n % 16) == 8)});
`endif
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_clk2"}, {31'd0, clk2MHz}, 32'd0);
        chk({nm, "_clk1"}, {31'd0, clk1MHz}, 32'd0);
`ifdef CLKDIV_STROBE_EN
        chk({nm, "_strb2"}, {31'd0, strb2MHz}, 32'd0);
        chk({nm, "_strb1"}, {31'd0, strb1MHz}, 32'd0);
`endif
    endtask

    // Release on the falling edge so no rising edge coincides with release.
    task automatic release_reset();
        @(negedge clk16MHz);
        reset = 1'b0;
        n     = 0;
    endtask

    // Called just after a step(): assert reset mid-cycle, check, then hold for some edges.
    task automatic async_reset(input int hold);
        #9;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        for (int i = 0; i < hold; i++) begin
            @(posedge clk16MHz);
            #1;
            check_zero("rst_held");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        time  rise2, fall2, rise1, fall1;
        logic p2, p1;
        int   cnt_s2, cnt_s1, hold, run;

        vecs[0]  = '{0,  1'b0, 1'b0};
        vecs[1]  = '{3,  1'b0, 1'b0};
        vecs[2]  = '{4,  1'b1, 1'b0};
        vecs[3]  = '{7,  1'b1, 1'b0};
        vecs[4]  = '{8,  1'b0, 1'b1};
        vecs[5]  = '{11, 1'b0, 1'b1};
        vecs[6]  = '{12, 1'b1, 1'b1};
        vecs[7]  = '{15, 1'b1, 1'b1};
        vecs[8]  = '{16, 1'b0, 1'b0};
        vecs[9]  = '{17, 1'b0, 1'b0};
        vecs[10] = '{20, 1'b1, 1'b0};
        vecs[11] = '{24, 1'b0, 1'b1};

        // Power-up reset window 0..50 ns, including the rising edge at 25 ns.
        #10;
        check_zero("pwr_rst_10ns");
        #30;
        check_zero("pwr_rst_40ns");

        release_reset();
        for (int v = 0; v < 12; v++) begin
            while (n < vecs[v].edge_n) step();
            chk($sformatf("vec%0d_clk2", v), {31'd0, clk2MHz}, {31'd0, vecs[v].exp2});
            chk($sformatf("vec%0d_clk1", v), {31'd0, clk1MHz}, {31'd0, vecs[v].exp1});
        end

        // Free run: measure periods and high times in ns from sampled transitions.
        rise2 = 0; fall2 = 0; rise1 = 0; fall1 = 0;
        p2 = clk2MHz; p1 = clk1MHz;
        cnt_s2 = 0; cnt_s1 = 0;
        while (n % 16 != 0) step();
        for (int i = 0; i < 200; i++) begin
            step();
`ifdef CLKDIV_STROBE_EN
            if (i < 160) begin
                cnt_s2 += int'(strb2MHz);
                cnt_s1 += int'(strb1MHz);
            end
`endif
            if (clk2MHz && !p2) begin
                if (rise2 != 0) chk("clk2_period_ns", 32'($time - rise2), 32'd400);
                rise2 = $time;
            end
            if (!clk2MHz && p2 && rise2 != 0) begin
                fall2 = $time;
                chk("clk2_high_ns", 32'(fall2 - rise2), 32'd200);
            end
            if (clk1MHz && !p1) begin
                if (rise1 != 0) chk("clk1_period_ns", 32'($time - rise1), 32'd800);
                rise1 = $time;
            end
            if (!clk1MHz && p1 && rise1 != 0) begin
                fall1 = $time;
                chk("clk1_high_ns", 32'(fall1 - rise1), 32'd400);
            end
            p2 = clk2MHz;
            p1 = clk1MHz;
        end
`ifdef CLKDIV_STROBE_EN
        chk("strb2_pulses_160", 32'(cnt_s2), 32'd20);
        chk("strb1_pulses_160", 32'(cnt_s1), 32'd10);
`endif

        // Mid-operation reset at cnt=13 (both outputs high), then recovery.
        while (n % 16 != 13) step();
        chk("pre_rst13_clk2", {31'd0, clk2MHz}, 32'd1);
        chk("pre_rst13_clk1", {31'd0, clk1MHz}, 32'd1);
        async_reset(0);
        release_reset();
        for (int i = 0; i < 3; i++) step();
        chk("recover_edge3_clk2", {31'd0, clk2MHz}, 32'd0);
        step();
        chk("recover_edge4_clk2", {31'd0, clk2MHz}, 32'd1);

        // Reset held across many edges mid-high-phase.
        async_reset(20);
        release_reset();
        check_zero("after_hold_release");

        // Randomized run lengths and reset hold times.
        for (int it = 0; it < 30; it++) begin
            run  = int'($urandom_range(40, 1));
            hold = int'($urandom_range(3, 0));
            for (int i = 0; i < run; i++) step();
            async_reset(hold);
            release_reset();
        end
        for (int i = 0; i < 20; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
